// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the memory-access stage.
//   - bus width constants (execute->memory, memory->write-back, forwarding)
//   - write-back select and CSR command encodings
//   - store FSM state encoding
//   - packed layouts of the three stage buses
//   - CSR read-modify-write helper functions
package cpu_pkg;

  localparam int ES_BUS_W  = 187;
  localparam int WB_BUS_W  = 70;
  localparam int FWD_BUS_W = 38;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_CSR = 3'd3;

  localparam logic [3:0] CSR_NONE = 4'd0;
  localparam logic [3:0] CSR_W    = 4'd1;
  localparam logic [3:0] CSR_S    = 4'd2;
  localparam logic [3:0] CSR_C    = 4'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } st_state_e;

  // Execute->memory bus, MSB first.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic [31:0] pc;
    logic [31:0] st_data;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1;
    logic [31:0] ld_data;
  } es_bus_t;

  // Memory->write-back bus.
  typedef struct packed {
    logic [31:0] wb_value;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] pc;
  } wb_bus_t;

  // Bypass bus back to decode.
  typedef struct packed {
    logic [31:0] wb_value;
    logic        rd_wen_fwd;
    logic [4:0]  rd;
  } fwd_bus_t;

  // True for the commands that modify the CSR; reserved codes act as NONE.
  function automatic logic csr_is_write(input logic [3:0] cmd);
    logic r;
    case (cmd)
      CSR_W, CSR_S, CSR_C: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  // New CSR value from the old value and the operand.
  function automatic logic [31:0] csr_next(input logic [3:0]  cmd,
                                           input logic [31:0] rdata,
                                           input logic [31:0] op1);
    logic [31:0] r;
    case (cmd)
      CSR_W:   r = op1;
      CSR_S:   r = rdata | op1;
      CSR_C:   r = rdata & ~op1;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: handshake and bus signals around the memory-access stage.
//   upstream   : exe_mem_bus_in, es_to_ms_valid, ms_allowin
//   downstream : ws_allowin, ms_to_ws_valid, mem_wb_bus_out
//   bypass     : mem_id_data_bus
//   data memory: dmem_wreq, dmem_waddr, dmem_wdata, dmem_wack
//   CSR file   : csr_addr, csr_rdata, csr_wen, csr_wdata
// master = the stage itself, slave = its surroundings.
interface mem_stage_if;
  import cpu_pkg::*;

  logic [ES_BUS_W-1:0]  exe_mem_bus_in;
  logic                 es_to_ms_valid;
  logic                 ms_allowin;
  logic                 ws_allowin;
  logic                 ms_to_ws_valid;
  logic [WB_BUS_W-1:0]  mem_wb_bus_out;
  logic [FWD_BUS_W-1:0] mem_id_data_bus;
  logic                 dmem_wreq;
  logic [31:0]          dmem_waddr;
  logic [31:0]          dmem_wdata;
  logic                 dmem_wack;
  logic [11:0]          csr_addr;
  logic [31:0]          csr_rdata;
  logic                 csr_wen;
  logic [31:0]          csr_wdata;

  modport master (
    input  exe_mem_bus_in, es_to_ms_valid, ws_allowin, dmem_wack, csr_rdata,
    output ms_allowin, ms_to_ws_valid, mem_wb_bus_out, mem_id_data_bus,
           dmem_wreq, dmem_waddr, dmem_wdata, csr_addr, csr_wen, csr_wdata
  );

  modport slave (
    output exe_mem_bus_in, es_to_ms_valid, ws_allowin, dmem_wack, csr_rdata,
    input  ms_allowin, ms_to_ws_valid, mem_wb_bus_out, mem_id_data_bus,
           dmem_wreq, dmem_waddr, dmem_wdata, csr_addr, csr_wen, csr_wdata
  );

endinterface

// File: rtl/mem_stage_store_ctrl.sv
// mem_store_ctrl: issues each store exactly once and tracks whether the
// current store has already been acknowledged while the stage is stalled.
//   clk, rst_n : clock, synchronous active-low reset
//   ms_valid   : stage holds a valid instruction
//   mem_we     : that instruction is a store
//   fire       : instruction leaves the stage this cycle
//   dmem_wack  : memory accepted the request this cycle
//   dmem_wreq  : store request (held until acknowledged)
//   ready_go   : instruction may leave the stage
module mem_store_ctrl
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ms_valid,
  input  logic mem_we,
  input  logic fire,
  input  logic dmem_wack,
  output logic dmem_wreq,
  output logic ready_go
);

  st_state_e state_q;
  logic      ack_s;

  // Request, effective acknowledge and ready decode.
  always_comb begin
    dmem_wreq = ms_valid && mem_we && (state_q == ST_IDLE);
    // An acknowledge only counts against a live request.
    ack_s     = dmem_wack && dmem_wreq;
    ready_go  = !mem_we || ack_s || (state_q == ST_DONE);
  end

  // Store FSM: remember an accepted store until the instruction leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ack_s && !fire) state_q <= ST_DONE;
          else                state_q <= ST_IDLE;
        end
        ST_DONE: begin
          if (fire) state_q <= ST_IDLE;
          else      state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mem_stage_if.master carrying the upstream/downstream handshake,
//           the write-back and bypass buses, the data-memory store port
//           and the CSR read/write port.
// Latches the execute->memory bus, issues stores, performs CSR
// read-modify-write on the leaving cycle and selects the write-back value.
module mem_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mem_stage_if.master   bus
);

  es_bus_t     bus_q;
  es_bus_t     bus_d;
  logic        ms_valid_q;
  logic        ms_valid_d;
  logic        ready_go_s;
  logic        ms_allowin_s;
  logic        ms_to_ws_valid_s;
  logic        fire_s;
  logic        dmem_wreq_s;
  logic [31:0] wb_value_s;
  wb_bus_t     wb_bus_s;
  fwd_bus_t    fwd_bus_s;
  logic        unused_mem_re;

  assign unused_mem_re = bus_q.mem_re;

  mem_store_ctrl u_store_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .ms_valid  (ms_valid_q),
    .mem_we    (bus_q.mem_we),
    .fire      (fire_s),
    .dmem_wack (bus.dmem_wack),
    .dmem_wreq (dmem_wreq_s),
    .ready_go  (ready_go_s)
  );

  // Pipeline handshake.
  always_comb begin
    ms_allowin_s     = !ms_valid_q || (ready_go_s && bus.ws_allowin);
    ms_to_ws_valid_s = ms_valid_q && ready_go_s;
    fire_s           = ms_to_ws_valid_s && bus.ws_allowin;
  end

  // Next-state of the pipeline register.
  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    if (ms_allowin_s) ms_valid_d = bus.es_to_ms_valid;
    else              ms_valid_d = ms_valid_q;
    if (bus.es_to_ms_valid && ms_allowin_s) bus_d = es_bus_t'(bus.exe_mem_bus_in);
    else                                    bus_d = bus_q;
  end

  // Pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      bus_q      <= bus_d;
    end
  end

  // Write-back value select; CSR reads return the pre-write value.
  always_comb begin
    wb_value_s = bus_q.alu_result;
    case (bus_q.wb_sel)
      WB_ALU:  wb_value_s = bus_q.alu_result;
      WB_MEM:  wb_value_s = bus_q.ld_data;
      WB_PC4:  wb_value_s = bus_q.pc + 32'd4;
      WB_CSR:  wb_value_s = bus.csr_rdata;
      default: wb_value_s = bus_q.alu_result;
    endcase
  end

  // Outgoing bus assembly.
  always_comb begin
    wb_bus_s.wb_value    = wb_value_s;
    wb_bus_s.rd          = bus_q.rd;
    wb_bus_s.rd_wen      = bus_q.rd_wen && ms_valid_q;
    wb_bus_s.pc          = bus_q.pc;
    fwd_bus_s.wb_value   = wb_value_s;
    fwd_bus_s.rd_wen_fwd = ms_valid_q && bus_q.rd_wen && (bus_q.rd != 5'd0);
    fwd_bus_s.rd         = bus_q.rd;
  end

  assign bus.ms_allowin      = ms_allowin_s;
  assign bus.ms_to_ws_valid  = ms_to_ws_valid_s;
  assign bus.mem_wb_bus_out  = wb_bus_s;
  assign bus.mem_id_data_bus = fwd_bus_s;
  assign bus.dmem_wreq       = dmem_wreq_s;
  assign bus.dmem_waddr      = bus_q.alu_result;
  assign bus.dmem_wdata      = bus_q.st_data;
  assign bus.csr_addr        = bus_q.csr_addr;
  // Writing only on the leaving cycle keeps a stalled CSR op from writing twice.
  assign bus.csr_wen         = fire_s && csr_is_write(bus_q.csr_cmd);
  assign bus.csr_wdata       = csr_next(bus_q.csr_cmd, bus.csr_rdata, bus_q.op1);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage.
module tb_mem_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   hs_cnt = 0;
  int   csr_cnt = 0;
  int   h0;
  int   c0;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted store handshakes and CSR write strobes.
  always @(posedge clk) begin
    if (ifc.dmem_wreq === 1'b1 && ifc.dmem_wack === 1'b1) hs_cnt <= hs_cnt + 1;
    if (ifc.csr_wen === 1'b1) csr_cnt <= csr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [186:0] mk_bus(
    input logic [31:0] alu, input logic [4:0] rd, input logic rd_wen, input logic we,
    input logic [2:0] sel, input logic [31:0] pc, input logic [31:0] st,
    input logic [3:0] cmd, input logic [11:0] caddr, input logic [31:0] op1,
    input logic [31:0] ld);
    return {alu, rd, rd_wen, we, 1'b0, sel, pc, st, cmd, caddr, op1, ld};
  endfunction

  function automatic logic [31:0] wbv();
    logic [69:0] b;
    b = ifc.mem_wb_bus_out;
    return b[69:38];
  endfunction

  initial begin
    rst_n = 1'b0;
    ifc.es_to_ms_valid = 1'b0;
    ifc.exe_mem_bus_in = '0;
    ifc.ws_allowin = 1'b1;
    ifc.dmem_wack = 1'b0;
    ifc.csr_rdata = 32'h0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk); #1;
    check_val("rst_valid",   ifc.ms_to_ws_valid, 1'b0);
    check_val("rst_allowin", ifc.ms_allowin, 1'b1);
    check_val("rst_wreq",    ifc.dmem_wreq, 1'b0);
    check_val("rst_csr_wen", ifc.csr_wen, 1'b0);
    check_val("rst_wb_bus",  ifc.mem_wb_bus_out, 70'h0);
    check_val("rst_fwd_bus", ifc.mem_id_data_bus, 38'h0);

    // Plain ALU op
    @(negedge clk);
    rst_n = 1'b1;
    ifc.exe_mem_bus_in = mk_bus(32'h1234, 5'd5, 1'b1, 1'b0, WB_ALU, 32'h1000, 32'h0,
                                CSR_NONE, 12'h0, 32'h0, 32'h0);
    ifc.es_to_ms_valid = 1'b1;
    #1;
    check_val("alu_allowin", ifc.ms_allowin, 1'b1);
    check_val("alu_pre_valid", ifc.ms_to_ws_valid, 1'b0);
    @(negedge clk);
    ifc.es_to_ms_valid = 1'b0;
    #1;
    check_val("alu_valid", ifc.ms_to_ws_valid, 1'b1);
    check_val("alu_wb_bus", ifc.mem_wb_bus_out, {32'h1234, 5'd5, 1'b1, 32'h1000});
    check_val("alu_fwd", ifc.mem_id_data_bus, {32'h1234, 1'b1, 5'd5});
    @(negedge clk); #1;
    check_val("alu_drain_valid", ifc.ms_to_ws_valid, 1'b0);
    check_val("alu_drain_wb_bus", ifc.mem_wb_bus_out, {32'h1234, 5'd5, 1'b0, 32'h1000});
    check_val("alu_drain_fwd", ifc.mem_id_data_bus, {32'h1234, 1'b0, 5'd5});

    // Store with acknowledge arriving in the third request cycle
    @(negedge clk);
    h0 = hs_cnt;
    ifc.exe_mem_bus_in = mk_bus(32'h80, 5'd0, 1'b0, 1'b1, WB_ALU, 32'h2000, 32'hDEADBEEF,
                                CSR_NONE, 12'h0, 32'h0, 32'h0);
    ifc.es_to_ms_valid = 1'b1;
    ifc.dmem_wack = 1'b0;
    @(negedge clk);
    ifc.es_to_ms_valid = 1'b0;
    ifc.exe_mem_bus_in = '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) ifc.dmem_wack = 1'b1;
      #1;
      check_val($sformatf("st_wreq_%0d", i),  ifc.dmem_wreq, 1'b1);
      check_val($sformatf("st_waddr_%0d", i), ifc.dmem_waddr, 32'h80);
      check_val($sformatf("st_wdata_%0d", i), ifc.dmem_wdata, 32'hDEADBEEF);
      check_val($sformatf("st_allowin_%0d", i), ifc.ms_allowin, (i == 2));
      check_val($sformatf("st_valid_%0d", i), ifc.ms_to_ws_valid, (i == 2));
    end
    @(negedge clk);
    ifc.dmem_wack = 1'b0;
    #1;
    check_val("st_after_wreq", ifc.dmem_wreq, 1'b0);
    check_val("st_after_valid", ifc.ms_to_ws_valid, 1'b0);
    check_val("st_handshakes", hs_cnt - h0, 1);

    // Store acked while write-back stalls for two cycles
    @(negedge clk);
    h0 = hs_cnt;
    ifc.exe_mem_bus_in = mk_bus(32'h100, 5'd0, 1'b0, 1'b1, WB_ALU, 32'h2100, 32'h55AA55AA,
                                CSR_NONE, 12'h0, 32'h0, 32'h0);
    ifc.es_to_ms_valid = 1'b1;
    ifc.ws_allowin = 1'b0;
    ifc.dmem_wack = 1'b1;
    @(negedge clk);
    ifc.es_to_ms_valid = 1'b0;
    #1;
    check_val("bp_wreq0", ifc.dmem_wreq, 1'b1);
    check_val("bp_valid0", ifc.ms_to_ws_valid, 1'b1);
    check_val("bp_allowin0", ifc.ms_allowin, 1'b0);
    @(negedge clk); #1;
    check_val("bp_wreq1", ifc.dmem_wreq, 1'b0);
    check_val("bp_valid1", ifc.ms_to_ws_valid, 1'b1);
    check_val("bp_allowin1", ifc.ms_allowin, 1'b0);
    check_val("bp_state_done", dut.u_store_ctrl.state_q, ST_DONE);
    check_val("bp_waddr", ifc.dmem_waddr, 32'h100);
    @(negedge clk);
    ifc.ws_allowin = 1'b1;
    ifc.dmem_wack = 1'b0;
    #1;
    check_val("bp_valid2", ifc.ms_to_ws_valid, 1'b1);
    check_val("bp_allowin2", ifc.ms_allowin, 1'b1);
    check_val("bp_wreq2", ifc.dmem_wreq, 1'b0);
    @(negedge clk); #1;
    check_val("bp_valid3", ifc.ms_to_ws_valid, 1'b0);
    check_val("bp_state_idle", dut.u_store_ctrl.state_q, ST_IDLE);
    check_val("bp_handshakes", hs_cnt - h0, 1);

    // CSRRS stalled two cycles
    @(negedge clk);
    c0 = csr_cnt;
    ifc.csr_rdata = 32'hF0;
    ifc.exe_mem_bus_in = mk_bus(32'h9999, 5'd7, 1'b1, 1'b0, WB_CSR, 32'h3000, 32'h0,
                                CSR_S, 12'h300, 32'h0F, 32'h0);
    ifc.es_to_ms_valid = 1'b1;
    ifc.ws_allowin = 1'b0;
    @(negedge clk);
    ifc.es_to_ms_valid = 1'b0;
    #1;
    check_val("csrs_wen0", ifc.csr_wen, 1'b0);
    check_val("csrs_valid", ifc.ms_to_ws_valid, 1'b1);
    check_val("csrs_wb_value", wbv(), 32'hF0);
    check_val("csrs_addr", ifc.csr_addr, 12'h300);
    check_val("csrs_fwd", ifc.mem_id_data_bus, {32'hF0, 1'b1, 5'd7});
    @(negedge clk); #1;
    check_val("csrs_wen1", ifc.csr_wen, 1'b0);
    @(negedge clk);
    ifc.ws_allowin = 1'b1;
    #1;
    check_val("csrs_wen2", ifc.csr_wen, 1'b1);
    check_val("csrs_wdata", ifc.csr_wdata, 32'hFF);
    @(negedge clk); #1;
    check_val("csrs_wen3", ifc.csr_wen, 1'b0);
    check_val("csrs_wen_count", csr_cnt - c0, 1);

    // Back-to-back: JAL wrap, load, CSRRC with wb_sel=5, CSRRW, reserved CSR cmd
    @(negedge clk);
    ifc.exe_mem_bus_in = mk_bus(32'h1111, 5'd0, 1'b1, 1'b0, WB_PC4, 32'hFFFFFFFC, 32'h0,
                                CSR_NONE, 12'h0, 32'h0, 32'h0);
    ifc.es_to_ms_valid = 1'b1;
    @(negedge clk);
    ifc.exe_mem_bus_in = mk_bus(32'h2222, 5'd3, 1'b1, 1'b0, WB_MEM, 32'h4000, 32'h0,
                                CSR_NONE, 12'h0, 32'h0, 32'hCAFEF00D);
    #1;
    check_val("jal_valid", ifc.ms_to_ws_valid, 1'b1);
    check_val("jal_wb_bus", ifc.mem_wb_bus_out, {32'h0, 5'd0, 1'b1, 32'hFFFFFFFC});
    check_val("jal_fwd", ifc.mem_id_data_bus, 38'h0);
    check_val("jal_allowin", ifc.ms_allowin, 1'b1);
    @(negedge clk);
    ifc.exe_mem_bus_in = mk_bus(32'h3333, 5'd4, 1'b1, 1'b0, 3'd5, 32'h4004, 32'h0,
                                CSR_C, 12'h305, 32'h30, 32'h0);
    #1;
    check_val("ld_wb_value", wbv(), 32'hCAFEF00D);
    check_val("ld_fwd", ifc.mem_id_data_bus, {32'hCAFEF00D, 1'b1, 5'd3});
    check_val("ld_csr_wen", ifc.csr_wen, 1'b0);
    @(negedge clk);
    ifc.exe_mem_bus_in = mk_bus(32'h4444, 5'd6, 1'b1, 1'b0, WB_ALU, 32'h4008, 32'h0,
                                CSR_W, 12'h340, 32'h12345678, 32'h0);
    #1;
    check_val("csrc_wb_value", wbv(), 32'h3333);
    check_val("csrc_wen", ifc.csr_wen, 1'b1);
    check_val("csrc_wdata", ifc.csr_wdata, 32'hC0);
    check_val("csrc_addr", ifc.csr_addr, 12'h305);
    @(negedge clk);
    ifc.exe_mem_bus_in = mk_bus(32'h5555, 5'd8, 1'b1, 1'b0, WB_ALU, 32'h400C, 32'h0,
                                4'd5, 12'h341, 32'hFFFF, 32'h0);
    #1;
    check_val("csrw_wen", ifc.csr_wen, 1'b1);
    check_val("csrw_wdata", ifc.csr_wdata, 32'h12345678);
    @(negedge clk);
    ifc.es_to_ms_valid = 1'b0;
    #1;
    check_val("csr_rsvd_valid", ifc.ms_to_ws_valid, 1'b1);
    check_val("csr_rsvd_wen", ifc.csr_wen, 1'b0);
    @(negedge clk); #1;
    check_val("b2b_drain_valid", ifc.ms_to_ws_valid, 1'b0);

    // Reset during an outstanding store
    @(negedge clk);
    ifc.exe_mem_bus_in = mk_bus(32'h200, 5'd0, 1'b0, 1'b1, WB_ALU, 32'h5000, 32'h11111111,
                                CSR_NONE, 12'h0, 32'h0, 32'h0);
    ifc.es_to_ms_valid = 1'b1;
    ifc.dmem_wack = 1'b0;
    @(negedge clk);
    ifc.es_to_ms_valid = 1'b0;
    #1;
    check_val("rs_wreq_pre", ifc.dmem_wreq, 1'b1);
    check_val("rs_allowin_pre", ifc.ms_allowin, 1'b0);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_val("rs_wreq", ifc.dmem_wreq, 1'b0);
    check_val("rs_valid", ifc.ms_to_ws_valid, 1'b0);
    check_val("rs_allowin", ifc.ms_allowin, 1'b1);
    check_val("rs_wb_bus", ifc.mem_wb_bus_out, 70'h0);
    rst_n = 1'b1;

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
